// File: rtl/sar_search_if.sv
// Comparator-side handshake of the SAR search: trial value out, relation code back.
interface sar_search_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] GUESS;
    logic             REQ;
    logic             ACK;
    logic [1:0]       CMP;

    modport master (output GUESS, output REQ, input ACK, input CMP);
    modport slave  (input GUESS, input REQ, output ACK, output CMP);
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller: resolves an unknown value MSB-first
// by probing a magnitude comparator, with early exit on equality.
module sar_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    sar_search_if.master     cmp,
    output logic             BUSY,
    output logic             DONE,
    output logic             FOUND,
    output logic             ERR,
    output logic [WIDTH-1:0] RESULT
);
    localparam logic [WIDTH-1:0] MSB_ONEHOT = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] bitptr_q, bitptr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] kept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            bitptr_q <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            bitptr_q <= bitptr_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        bitptr_d = bitptr_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        trial    = acc_q | bitptr_q;
        kept     = acc_q | ((cmp.CMP == 2'b01) ? bitptr_q : '0);

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d  = S_PROBE;
                    acc_d    = '0;
                    bitptr_d = MSB_ONEHOT;
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_PROBE: begin
                // Without ACK every register holds, keeping GUESS stable.
                if (cmp.ACK) begin
                    unique case (cmp.CMP)
                        2'b00: begin
                            result_d = trial;
                            found_d  = 1'b1;
                            state_d  = S_DONE;
                        end
                        2'b11: begin
                            result_d = acc_q;
                            err_d    = 1'b1;
                            state_d  = S_DONE;
                        end
                        default: begin
                            acc_d = kept;
                            if (bitptr_q[0]) begin
                                result_d = kept;
                                found_d  = 1'b0;
                                state_d  = S_DONE;
                            end else begin
                                bitptr_d = bitptr_q >> 1;
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmp.GUESS = (state_q == S_PROBE) ? trial : '0;
    assign cmp.REQ   = (state_q == S_PROBE);
    assign BUSY      = (state_q == S_PROBE);
    assign DONE      = (state_q == S_DONE);
    assign FOUND     = found_q;
    assign ERR       = err_q;
    assign RESULT    = result_q;
endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a comparator responder, a transaction-level
// search planner as reference, and directed searches with hand-computed results.
module tb_sar_search;
    localparam int unsigned W = 4;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         START = 1'b0;
    logic         BUSY, DONE, FOUND, ERR;
    logic [W-1:0] RESULT;

    sar_search_if #(.WIDTH(W)) cmp_if ();

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .START  (START),
        .cmp    (cmp_if),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .FOUND  (FOUND),
        .ERR    (ERR),
        .RESULT (RESULT)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Environment: the unknown value and how the comparator answers.
    logic [W-1:0] target     = '0;
    int           ack_delay  = 0;
    int           illegal_at = -1;
    int           trial_no   = 0;
    int           wait_cnt   = 0;

    // Reference: the full list of trials a search must make, plus its outcome.
    int plan_q[$];
    int plan_res;
    bit plan_found;
    bit plan_err;

    function automatic void plan(input int tgt, input int ill);
        int acc;
        int g;
        acc = 0;
        plan_q.delete();
        plan_res   = 0;
        plan_found = 1'b0;
        plan_err   = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            g = acc | (1 << i);
            plan_q.push_back(g);
            if (plan_q.size() - 1 == ill) begin
                plan_res = acc;
                plan_err = 1'b1;
                return;
            end
            if (g == tgt) begin
                plan_res   = g;
                plan_found = 1'b1;
                return;
            end
            if (tgt > g) acc = g;
        end
        plan_res = acc;
    endfunction

    logic         exp_busy  = 1'b0;
    logic         exp_done  = 1'b0;
    logic         exp_found = 1'b0;
    logic         exp_err   = 1'b0;
    logic [W-1:0] exp_guess = '0;
    logic [W-1:0] exp_result = '0;

    // Advance the expected view after each edge, from the inputs that edge saw.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            exp_busy = 1'b0; exp_done = 1'b0; exp_found = 1'b0; exp_err = 1'b0;
            exp_guess = '0; exp_result = '0; trial_no = 0; wait_cnt = 0;
        end else if (exp_done) begin
            exp_done = 1'b0;
        end else if (!exp_busy) begin
            if (START) begin
                plan(int'(target), illegal_at);
                exp_busy   = 1'b1;
                exp_guess  = W'(plan_q[0]);
                exp_result = '0;
                exp_found  = 1'b0;
                exp_err    = 1'b0;
                trial_no   = 0;
                wait_cnt   = 0;
            end
        end else if (cmp_if.ACK) begin
            void'(plan_q.pop_front());
            trial_no++;
            wait_cnt = 0;
            if (plan_q.size() == 0) begin
                exp_busy   = 1'b0;
                exp_done   = 1'b1;
                exp_guess  = '0;
                exp_result = W'(plan_res);
                exp_found  = plan_found;
                exp_err    = plan_err;
            end else begin
                exp_guess = W'(plan_q[0]);
            end
        end else begin
            wait_cnt++;
        end
    end

    // Comparator responder: relation of target vs GUESS, ACK after ack_delay idle cycles.
    always begin
        @(negedge clk);
        #1;
        cmp_if.ACK = (wait_cnt >= ack_delay);
        if (trial_no == illegal_at)        cmp_if.CMP = 2'b11;
        else if (target == cmp_if.GUESS)   cmp_if.CMP = 2'b00;
        else if (target > cmp_if.GUESS)    cmp_if.CMP = 2'b01;
        else                               cmp_if.CMP = 2'b10;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   BUSY,       exp_busy);
            check("req",    cmp_if.REQ, exp_busy);
            check("done",   DONE,       exp_done);
            if (exp_busy) check("guess", cmp_if.GUESS, exp_guess);
            check("result", RESULT,     exp_result);
            check("found",  FOUND,      exp_found);
            check("err",    ERR,        exp_err);
        end
    end

    task automatic run_search(input logic [W-1:0] tgt, input int dly, input int ill,
                              input bit noise, input logic [W-1:0] x_res,
                              input bit x_found, input bit x_err, input int x_lat);
        int cnt;
        bit seen;
        target     = tgt;
        ack_delay  = dly;
        illegal_at = ill;
        @(negedge clk);
        START = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (!noise) START = 1'b0;
            if (DONE) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            START = 1'b0;
            return;
        end
        check("lat_lit",    cnt,    x_lat);
        check("result_lit", RESULT, x_res);
        check("found_lit",  FOUND,  x_found);
        check("err_lit",    ERR,    x_err);
        if (noise) begin
            @(negedge clk);
            START = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pin_g[4];
        int cnt;
        pin_g = '{8, 4, 6, 5};
        cmp_if.ACK = 1'b1;
        cmp_if.CMP = 2'b00;

        plan(5, -1);
        check("plan_len", plan_q.size(), 4);
        for (int k = 0; k < 4; k++) check("plan_guess", plan_q[k], pin_g[k]);
        check("plan_found", plan_found, 1);
        plan(0, -1);
        check("plan_zero_res", plan_res, 0);
        check("plan_zero_found", plan_found, 0);
        plan(10, 1);
        check("plan_ill_res", plan_res, 8);
        check("plan_ill_err", plan_err, 1);

        repeat (2) @(negedge clk);
        check("rst_guess",  cmp_if.GUESS, 0);
        check("rst_req",    cmp_if.REQ,   0);
        check("rst_busy",   BUSY,   0);
        check("rst_done",   DONE,   0);
        check("rst_found",  FOUND,  0);
        check("rst_err",    ERR,    0);
        check("rst_result", RESULT, 0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_search(4'b0101, 0, -1, 1'b0, 4'b0101, 1'b1, 1'b0, 5);
        run_search(4'b1000, 0, -1, 1'b0, 4'b1000, 1'b1, 1'b0, 2);
        run_search(4'b0000, 0, -1, 1'b0, 4'b0000, 1'b0, 1'b0, 5);
        run_search(4'b1111, 0, -1, 1'b0, 4'b1111, 1'b1, 1'b0, 5);
        run_search(4'b0011, 3, -1, 1'b1, 4'b0011, 1'b1, 1'b0, 17);
        run_search(4'b1010, 0,  1, 1'b0, 4'b1000, 1'b0, 1'b1, 3);
        run_search(4'b0011, 0, -1, 1'b0, 4'b0011, 1'b1, 1'b0, 5);

        // Abort in the middle of the third trial.
        target     = 4'b0110;
        ack_delay  = 2;
        illegal_at = -1;
        @(negedge clk);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        cnt = 0;
        while (trial_no != 2 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_trial3", trial_no, 2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_guess",  cmp_if.GUESS, 0);
        check("abort_req",    cmp_if.REQ,   0);
        check("abort_busy",   BUSY,   0);
        check("abort_done",   DONE,   0);
        check("abort_found",  FOUND,  0);
        check("abort_result", RESULT, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_done", DONE, 0);
        run_search(4'b0110, 0, -1, 1'b0, 4'b0110, 1'b1, 1'b0, 4);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
